// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_if
// Brief    : IF/WB-facing inputs and ID/EX-facing outputs of the decode stage
// Revision : 1.0
// ============================================================================
interface id_stage_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               freeze;
    logic               flush;
    logic               valid_in;
    logic [DATA_W-1:0]  pc;
    logic [31:0]        instruction;
    logic               wb_en;
    logic [RADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]  wb_result;
    logic               hazard_stall;
    logic               ex_valid;
    logic               ex_wb_en;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic [1:0]         ex_br;
    logic [3:0]         ex_exe_cmd;
    logic [DATA_W-1:0]  ex_val1;
    logic [DATA_W-1:0]  ex_val2;
    logic [DATA_W-1:0]  ex_reg2;
    logic [RADDR_W-1:0] ex_dest;
    logic [RADDR_W-1:0] ex_src1;
    logic [RADDR_W-1:0] ex_src2;
    logic [DATA_W-1:0]  ex_pc;

    modport master (
        output freeze, flush, valid_in, pc, instruction, wb_en, wb_dest, wb_result,
        input  hazard_stall, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_br,
               ex_exe_cmd, ex_val1, ex_val2, ex_reg2, ex_dest, ex_src1, ex_src2, ex_pc
    );

    modport slave (
        input  freeze, flush, valid_in, pc, instruction, wb_en, wb_dest, wb_result,
        output hazard_stall, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_br,
               ex_exe_cmd, ex_val1, ex_val2, ex_reg2, ex_dest, ex_src1, ex_src2, ex_pc
    );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Brief    : MIPS decode stage: register file with bypass, decode, immediate,
//            load-use hazard detection and ID/EX register with freeze/flush
// Revision : 1.0
// ============================================================================
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter bit SIGN_EXT = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    id_stage_pipe_if.slave bus
);
    localparam int         c_NREG   = 1 << RADDR_W;
    localparam logic [5:0] c_OP_ADD = 6'd1,  c_OP_SUB = 6'd3,  c_OP_AND  = 6'd5;
    localparam logic [5:0] c_OP_OR  = 6'd6,  c_OP_NOR = 6'd7,  c_OP_XOR  = 6'd8;
    localparam logic [5:0] c_OP_SLA = 6'd9,  c_OP_SLL = 6'd10, c_OP_SRA  = 6'd11;
    localparam logic [5:0] c_OP_SRL = 6'd12, c_OP_ADDI = 6'd32, c_OP_SUBI = 6'd33;
    localparam logic [5:0] c_OP_LD  = 6'd36, c_OP_ST  = 6'd37, c_OP_BEZ  = 6'd40;
    localparam logic [5:0] c_OP_BNE = 6'd41, c_OP_JMP = 6'd42;

    logic [DATA_W-1:0]  r_rf [c_NREG];
    logic               r_ex_valid, r_ex_wb_en, r_ex_mem_read, r_ex_mem_write;
    logic [1:0]         r_ex_br;
    logic [3:0]         r_ex_exe_cmd;
    logic [DATA_W-1:0]  r_ex_val1, r_ex_val2, r_ex_reg2, r_ex_pc;
    logic [RADDR_W-1:0] r_ex_dest, r_ex_src1, r_ex_src2;

    logic [5:0]         w_op;
    logic [RADDR_W-1:0] w_src1, w_src2, w_rd, w_dest;
    logic [DATA_W-1:0]  w_imm, w_rd1, w_rd2;
    logic [3:0]         w_cmd;
    logic [1:0]         w_br;
    logic               w_rtype, w_wb, w_mr, w_mw, w_two, w_use_src1;
    logic               w_stall, w_bubble;

    assign w_op   = bus.instruction[31:26];
    assign w_src1 = bus.instruction[21 +: RADDR_W];
    assign w_src2 = bus.instruction[16 +: RADDR_W];
    assign w_rd   = bus.instruction[11 +: RADDR_W];

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_imm
        if (gi < 16) begin : g_low
            assign w_imm[gi] = bus.instruction[gi];
        end else begin : g_ext
            assign w_imm[gi] = SIGN_EXT ? bus.instruction[15] : 1'b0;
        end
    end

    always_comb begin
        w_cmd      = 4'b0000;
        w_rtype    = 1'b0;
        w_wb       = 1'b0;
        w_mr       = 1'b0;
        w_mw       = 1'b0;
        w_br       = 2'd0;
        w_two      = 1'b0;
        w_use_src1 = 1'b1;
        case (w_op)
            c_OP_ADD:  w_rtype = 1'b1;
            c_OP_SUB:  begin w_rtype = 1'b1; w_cmd = 4'b0010; end
            c_OP_AND:  begin w_rtype = 1'b1; w_cmd = 4'b0100; end
            c_OP_OR:   begin w_rtype = 1'b1; w_cmd = 4'b0101; end
            c_OP_NOR:  begin w_rtype = 1'b1; w_cmd = 4'b0110; end
            c_OP_XOR:  begin w_rtype = 1'b1; w_cmd = 4'b0111; end
            c_OP_SLA,
            c_OP_SLL:  begin w_rtype = 1'b1; w_cmd = 4'b1000; end
            c_OP_SRA:  begin w_rtype = 1'b1; w_cmd = 4'b1001; end
            c_OP_SRL:  begin w_rtype = 1'b1; w_cmd = 4'b1010; end
            c_OP_ADDI: w_wb = 1'b1;
            c_OP_SUBI: begin w_wb = 1'b1; w_cmd = 4'b0010; end
            c_OP_LD:   begin w_wb = 1'b1; w_mr = 1'b1; end
            c_OP_ST:   begin w_mw = 1'b1; w_two = 1'b1; end
            c_OP_BEZ:  w_br = 2'd1;
            c_OP_BNE:  begin w_br = 2'd2; w_two = 1'b1; end
            c_OP_JMP:  begin w_br = 2'd3; w_use_src1 = 1'b0; end
            default:   w_use_src1 = 1'b0;
        endcase
        if (w_rtype) begin
            w_wb  = 1'b1;
            w_two = 1'b1;
        end
    end

    assign w_dest = w_rtype ? w_rd : (w_wb ? w_src2 : '0);

    // Write-first: a same-cycle write-back is visible to the reading instruction.
    assign w_rd1 = (w_src1 == '0) ? '0 :
                   (bus.wb_en && bus.wb_dest == w_src1) ? bus.wb_result : r_rf[w_src1];
    assign w_rd2 = (w_src2 == '0) ? '0 :
                   (bus.wb_en && bus.wb_dest == w_src2) ? bus.wb_result : r_rf[w_src2];

    assign w_stall = r_ex_valid && r_ex_mem_read && (r_ex_dest != '0) &&
                     ((r_ex_dest == w_src1) || (w_two && r_ex_dest == w_src2)) &&
                     bus.valid_in && w_use_src1;

    assign w_bubble = bus.flush || (!bus.freeze && (w_stall || !bus.valid_in));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREG; i++) r_rf[i] <= '0;
        end else if (bus.wb_en && bus.wb_dest != '0) begin
            r_rf[bus.wb_dest] <= bus.wb_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_ex_valid     <= 1'b0;
            r_ex_wb_en     <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_br        <= 2'd0;
            r_ex_exe_cmd   <= 4'b0000;
            r_ex_val1      <= '0;
            r_ex_val2      <= '0;
            r_ex_reg2      <= '0;
            r_ex_dest      <= '0;
            r_ex_src1      <= '0;
            r_ex_src2      <= '0;
            r_ex_pc        <= '0;
        end else if (!bus.freeze) begin
            r_ex_valid     <= 1'b1;
            r_ex_wb_en     <= w_wb;
            r_ex_mem_read  <= w_mr;
            r_ex_mem_write <= w_mw;
            r_ex_br        <= w_br;
            r_ex_exe_cmd   <= w_cmd;
            r_ex_val1      <= w_rd1;
            r_ex_val2      <= w_rtype ? w_rd2 : w_imm;
            r_ex_reg2      <= w_rd2;
            r_ex_dest      <= w_dest;
            r_ex_src1      <= w_src1;
            r_ex_src2      <= w_src2;
            r_ex_pc        <= bus.pc;
        end
    end

    assign bus.hazard_stall = w_stall;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_wb_en     = r_ex_wb_en;
    assign bus.ex_mem_read  = r_ex_mem_read;
    assign bus.ex_mem_write = r_ex_mem_write;
    assign bus.ex_br        = r_ex_br;
    assign bus.ex_exe_cmd   = r_ex_exe_cmd;
    assign bus.ex_val1      = r_ex_val1;
    assign bus.ex_val2      = r_ex_val2;
    assign bus.ex_reg2      = r_ex_reg2;
    assign bus.ex_dest      = r_ex_dest;
    assign bus.ex_src1      = r_ex_src1;
    assign bus.ex_src2      = r_ex_src2;
    assign bus.ex_pc        = r_ex_pc;
endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipe
// Brief    : Scoreboard bench for id_stage_pipe (32-bit sign/zero-ext, 16-bit)
// Revision : 1.0
// ============================================================================
module tb_id_stage_pipe;
    typedef struct packed {
        logic        v, wb, mr, mw;
        logic [1:0]  br;
        logic [3:0]  cmd;
        logic [31:0] v1, v2, r2, p;
        logic [4:0]  dest;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in, wb_en;
    logic [31:0] pc, instr, wb_result;
    logic [4:0]  wb_dest;
    logic        n_rst, n_valid, n_wb_en;
    logic [31:0] n_instr;
    logic [15:0] n_wb_result;
    logic [2:0]  n_wb_dest;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        q[$];
    exp_t        e_hold, e_ld;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(32), .RADDR_W(5)) ifc_a ();
    id_stage_pipe_if #(.DATA_W(32), .RADDR_W(5)) ifc_z ();
    id_stage_pipe_if #(.DATA_W(16), .RADDR_W(3)) ifc_n ();

    id_stage_pipe #(.DATA_W(32), .RADDR_W(5), .SIGN_EXT(1'b1)) dut_a (.clk(clk), .rst(rst),   .bus(ifc_a));
    id_stage_pipe #(.DATA_W(32), .RADDR_W(5), .SIGN_EXT(1'b0)) dut_z (.clk(clk), .rst(rst),   .bus(ifc_z));
    id_stage_pipe #(.DATA_W(16), .RADDR_W(3), .SIGN_EXT(1'b1)) dut_n (.clk(clk), .rst(n_rst), .bus(ifc_n));

    assign ifc_a.freeze = freeze;   assign ifc_z.freeze = freeze;
    assign ifc_a.flush = flush;     assign ifc_z.flush = flush;
    assign ifc_a.valid_in = valid_in; assign ifc_z.valid_in = valid_in;
    assign ifc_a.pc = pc;           assign ifc_z.pc = pc;
    assign ifc_a.instruction = instr; assign ifc_z.instruction = instr;
    assign ifc_a.wb_en = wb_en;     assign ifc_z.wb_en = wb_en;
    assign ifc_a.wb_dest = wb_dest; assign ifc_z.wb_dest = wb_dest;
    assign ifc_a.wb_result = wb_result; assign ifc_z.wb_result = wb_result;

    assign ifc_n.freeze = 1'b0;
    assign ifc_n.flush = 1'b0;
    assign ifc_n.valid_in = n_valid;
    assign ifc_n.pc = 16'h0040;
    assign ifc_n.instruction = n_instr;
    assign ifc_n.wb_en = n_wb_en;
    assign ifc_n.wb_dest = n_wb_dest;
    assign ifc_n.wb_result = n_wb_result;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic exp_t mk(input bit wb, input bit mr, input bit mw, input int br,
                                input int cmd, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] r2, input int dest);
        exp_t e;
        e = '0;
        e.v = 1'b1; e.wb = wb; e.mr = mr; e.mw = mw;
        e.br = br[1:0]; e.cmd = cmd[3:0];
        e.v1 = v1; e.v2 = v2; e.r2 = r2; e.p = pc; e.dest = dest[4:0];
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        check_val("sb_depth", q.size(), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check_val("ex_valid", ifc_a.ex_valid, e.v);
            check_val("ex_wb_en", ifc_a.ex_wb_en, e.wb);
            check_val("ex_mem_read", ifc_a.ex_mem_read, e.mr);
            check_val("ex_mem_write", ifc_a.ex_mem_write, e.mw);
            check_val("ex_br", ifc_a.ex_br, e.br);
            check_val("ex_exe_cmd", ifc_a.ex_exe_cmd, e.cmd);
            check_val("ex_val1", ifc_a.ex_val1, e.v1);
            check_val("ex_val2", ifc_a.ex_val2, e.v2);
            check_val("ex_reg2", ifc_a.ex_reg2, e.r2);
            check_val("ex_dest", ifc_a.ex_dest, e.dest);
            check_val("ex_pc", ifc_a.ex_pc, e.p);
        end
        pc = pc + 32'd4;
    endtask

    task automatic step(input exp_t e);
        q.push_back(e);
        cyc();
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        check_val(tag, ifc_a.hazard_stall, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; valid_in = 1'b0; pc = 32'h400;
        instr = 32'd0; wb_en = 1'b0; wb_dest = 5'd0; wb_result = 32'd0;
        n_rst = 1'b1; n_valid = 1'b0; n_wb_en = 1'b0; n_instr = 32'd0;
        n_wb_dest = 3'd0; n_wb_result = 16'd0;

        step('0);
        step('0);
        check_val("reset_stall", ifc_a.hazard_stall, 1'b0);
        rst = 1'b0;
        valid_in = 1'b1;

        for (int i = 1; i < 32; i++) begin
            instr = enc_r(1, i, i, 1);
            step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        end

        wb_en = 1'b1; wb_dest = 5'd0; wb_result = 32'hFFFF_FFFF;
        instr = enc_r(1, 0, 0, 1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        wb_en = 1'b0;
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));

        wb_en = 1'b1; wb_dest = 5'd5; wb_result = 32'h1234;
        instr = enc_r(1, 5, 5, 3);
        step(mk(1, 0, 0, 0, 0, 32'h1234, 32'h1234, 32'h1234, 3));
        e_hold = mk(1, 0, 0, 0, 0, 32'h1234, 32'h1234, 32'h1234, 3);

        wb_dest = 5'd1; wb_result = 32'h11; valid_in = 1'b0;
        step('0);
        wb_en = 1'b0; valid_in = 1'b1;

        instr = enc_i(32, 1, 2, 16'hFFFE);
        step(mk(1, 0, 0, 0, 0, 32'h11, 32'hFFFF_FFFE, 0, 2));
        check_val("addi_zext_val2", ifc_z.ex_val2, 32'h0000_FFFE);
        check_val("addi_zext_dest", ifc_z.ex_dest, 5'd2);

        instr = enc_i(33, 5, 8, 16'h0003);
        step(mk(1, 0, 0, 0, 4'b0010, 32'h1234, 32'h3, 0, 8));

        begin
            int ops[9]  = '{3, 5, 6, 7, 8, 9, 10, 11, 12};
            int cmds[9] = '{2, 4, 5, 6, 7, 8, 8, 9, 10};
            for (int k = 0; k < 9; k++) begin
                instr = enc_r(ops[k], 5, 1, 7);
                step(mk(1, 0, 0, 0, cmds[k], 32'h1234, 32'h11, 32'h11, 7));
            end
        end

        // load-use on src1
        instr = enc_i(36, 1, 4, 8);
        step(mk(1, 1, 0, 0, 0, 32'h11, 32'h8, 0, 4));
        instr = enc_r(1, 4, 1, 6);
        chk_stall("stall_ld_src1", 1'b1);
        step('0);
        chk_stall("stall_release", 1'b0);
        step(mk(1, 0, 0, 0, 0, 0, 32'h11, 32'h11, 6));

        // load-use on src2 of a two-source op
        instr = enc_i(36, 1, 4, 8);
        step(mk(1, 1, 0, 0, 0, 32'h11, 32'h8, 0, 4));
        instr = enc_i(41, 1, 4, 16'h0020);
        chk_stall("stall_bne_src2", 1'b1);
        step('0);
        step(mk(0, 0, 0, 2, 0, 32'h11, 32'h20, 0, 0));

        instr = enc_i(36, 1, 4, 8);
        step(mk(1, 1, 0, 0, 0, 32'h11, 32'h8, 0, 4));
        instr = enc_i(40, 7, 4, 16'h0010);
        chk_stall("nostall_bez", 1'b0);
        step(mk(0, 0, 0, 1, 0, 0, 32'h10, 0, 0));

        instr = enc_i(36, 1, 4, 8);
        step(mk(1, 1, 0, 0, 0, 32'h11, 32'h8, 0, 4));
        instr = {6'd0, 5'd4, 5'd4, 16'd0};
        chk_stall("nostall_nop", 1'b0);
        instr = enc_i(42, 4, 4, 16'h0100);
        chk_stall("nostall_jmp", 1'b0);
        step(mk(0, 0, 0, 3, 0, 0, 32'h100, 0, 0));

        // freeze holds; hazard stays live; write-back still lands
        instr = enc_i(36, 1, 4, 8);
        e_ld = mk(1, 1, 0, 0, 0, 32'h11, 32'h8, 0, 4);
        step(e_ld);
        freeze = 1'b1;
        instr = enc_r(1, 4, 1, 6);
        wb_en = 1'b1; wb_dest = 5'd9; wb_result = 32'h99;
        chk_stall("stall_in_freeze", 1'b1);
        step(e_ld);
        freeze = 1'b0; wb_en = 1'b0;
        step('0);
        step(mk(1, 0, 0, 0, 0, 0, 32'h11, 32'h11, 6));

        instr = enc_r(1, 5, 5, 3);
        e_hold.p = pc;
        step(e_hold);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = enc_r(3, 9, k + 1, 10 + k);
            step(e_hold);
        end
        flush = 1'b1;
        step('0);
        freeze = 1'b0; flush = 1'b0;

        instr = enc_r(1, 9, 9, 10);
        step(mk(1, 0, 0, 0, 0, 32'h99, 32'h99, 32'h99, 10));
        flush = 1'b1;
        step('0);
        flush = 1'b0;

        instr = {6'd63, 26'd0};
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        instr = enc_i(37, 5, 9, 16'h8001);
        step(mk(0, 0, 1, 0, 0, 32'h1234, 32'hFFFF_8001, 32'h99, 0));

        rst = 1'b1;
        instr = enc_r(1, 5, 5, 3);
        step('0);
        rst = 1'b0;
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 3));

        // 16-bit datapath, 8-register build
        valid_in = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b0;
        n_wb_en = 1'b1; n_wb_dest = 3'd3; n_wb_result = 16'h5A5A;
        @(posedge clk); #1;
        n_wb_dest = 3'd2; n_wb_result = 16'h0102;
        @(posedge clk); #1;
        n_wb_en = 1'b0;
        n_valid = 1'b1;
        n_instr = {6'd37, 5'd2, 5'd3, 16'h8001};
        @(posedge clk); #1;
        check_val("n_ex_valid", ifc_n.ex_valid, 1'b1);
        check_val("n_ex_val1", ifc_n.ex_val1, 16'h0102);
        check_val("n_ex_val2", ifc_n.ex_val2, 16'h8001);
        check_val("n_ex_reg2", ifc_n.ex_reg2, 16'h5A5A);
        check_val("n_ex_mem_write", ifc_n.ex_mem_write, 1'b1);
        check_val("n_ex_wb_en", ifc_n.ex_wb_en, 1'b0);
        check_val("n_ex_dest", ifc_n.ex_dest, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
